// File: rtl/pcie_msix_shdw_tracker_pkg.sv
// Shared types and constants for the MSI-X control-shadow tracker.
// Optional TPH capture is enabled by defining MSIX_SHDW_TPH_EN.
package pcie_msix_shdw_pkg;

    localparam int SHDW_VF_NUM_W = 11;
    localparam int SHDW_PF_NUM_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SCAN  = 2'd2,
        TRACK = 2'd3
    } t_shdw_state;

    typedef struct packed {
        logic       ats_en;
        logic       tph_req_en;
        logic [1:0] tph_st_mode;
        logic       msix_en;
        logic       fn_mask;
        logic       bme;
    } t_shdw_cfg;

    // Width of a counter that must hold values 0..n without wrapping.
    function automatic int shdw_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pcie_msix_shdw_tracker_if.sv
// Shadow-update, lookup and status bundle between the PCIe EP side and the tracker.
// TPH status signals exist only when MSIX_SHDW_TPH_EN is defined.
interface pcie_msix_shdw_tracker_if #(
    parameter int NUM_PFS = 1,
    parameter int NUM_VFS = 4
) ();
    import pcie_msix_shdw_pkg::*;

    logic                      resync_req;
    logic                      ctl_shdw_update;
    logic [SHDW_PF_NUM_W-1:0]  ctl_shdw_pf_num;
    logic [SHDW_VF_NUM_W-1:0]  ctl_shdw_vf_num;
    logic                      ctl_shdw_vf_active;
    logic [6:0]                ctl_shdw_cfg;
    logic                      ctl_shdw_req_all;

    logic [NUM_PFS-1:0]        pf_msix_en;
    logic [NUM_PFS-1:0]        pf_msix_mask;
    logic [NUM_PFS-1:0]        pf_bme;
    logic [NUM_VFS-1:0]        vf_msix_en;
    logic [NUM_VFS-1:0]        vf_msix_mask;

    logic                      lkup_valid;
    logic                      lkup_vf_active;
    logic [SHDW_VF_NUM_W-1:0]  lkup_num;
    logic                      lkup_rsp_valid;
    logic                      lkup_rsp_en;
    logic                      lkup_rsp_mask;

    logic                      shdw_synced;
    logic                      shdw_range_err;

`ifdef MSIX_SHDW_TPH_EN
    logic [NUM_VFS-1:0]        vf_tph_en;
    logic [2*NUM_VFS-1:0]      vf_tph_st_mode;
    logic [NUM_PFS-1:0]        pf_tph_en;
    logic [2*NUM_PFS-1:0]      pf_tph_st_mode;
`endif

    modport master (
        output resync_req, ctl_shdw_update, ctl_shdw_pf_num, ctl_shdw_vf_num,
               ctl_shdw_vf_active, ctl_shdw_cfg, lkup_valid, lkup_vf_active, lkup_num,
        input  ctl_shdw_req_all, pf_msix_en, pf_msix_mask, pf_bme, vf_msix_en,
               vf_msix_mask, lkup_rsp_valid, lkup_rsp_en, lkup_rsp_mask,
               shdw_synced, shdw_range_err
`ifdef MSIX_SHDW_TPH_EN
        , input vf_tph_en, vf_tph_st_mode, pf_tph_en, pf_tph_st_mode
`endif
    );

    modport slave (
        input  resync_req, ctl_shdw_update, ctl_shdw_pf_num, ctl_shdw_vf_num,
               ctl_shdw_vf_active, ctl_shdw_cfg, lkup_valid, lkup_vf_active, lkup_num,
        output ctl_shdw_req_all, pf_msix_en, pf_msix_mask, pf_bme, vf_msix_en,
               vf_msix_mask, lkup_rsp_valid, lkup_rsp_en, lkup_rsp_mask,
               shdw_synced, shdw_range_err
`ifdef MSIX_SHDW_TPH_EN
        , output vf_tph_en, vf_tph_st_mode, pf_tph_en, pf_tph_st_mode
`endif
    );

endinterface

// File: rtl/pcie_msix_shdw_tracker_seq.sv
// Startup/resync sequencer: issues the req_all pulse, then counts accepted
// updates (or times out) before declaring the shadow copy synced.
module pcie_msix_shdw_seq
    import pcie_msix_shdw_pkg::*;
#(
    parameter int NUM_FUNCS    = 5,
    parameter int SCAN_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic resync_req_i,
    input  logic upd_acc_i,
    output logic req_all_o,
    output logic synced_o
);

    localparam int CNT_W = shdw_cnt_w(NUM_FUNCS);
    localparam int TMO_W = (SCAN_TIMEOUT > 1) ? $clog2(SCAN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(NUM_FUNCS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SCAN_TIMEOUT - 1);

    t_shdw_state      state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             req_all_q;
    logic             synced_q;

    // Both counters saturate; the exit test uses the post-increment values so
    // the transition lands on the edge that samples the final update/cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_acc_i && (cnt_q != CNT_TGT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            req_all_q <= 1'b0;
            synced_q  <= 1'b0;
        end else begin
            req_all_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q   <= REQ;
                    req_all_q <= 1'b1;
                end
                REQ: begin
                    cnt_q <= '0;
                    tmo_q <= '0;
                    if (resync_req_i) begin
                        req_all_q <= 1'b1;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (resync_req_i) begin
                        state_q   <= REQ;
                        req_all_q <= 1'b1;
                    end else if ((cnt_d == CNT_TGT) || (tmo_d == TMO_LAST)) begin
                        state_q  <= TRACK;
                        synced_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                        tmo_q <= tmo_d;
                    end
                end
                TRACK: begin
                    if (resync_req_i) begin
                        state_q   <= REQ;
                        req_all_q <= 1'b1;
                        synced_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_all_o = req_all_q;
    assign synced_o  = synced_q;

endmodule

// File: rtl/pcie_msix_shdw_tracker.sv
// Per-PF/VF MSI-X enable, mask and BME shadow table with a 1-cycle lookup port.
// Define MSIX_SHDW_TPH_EN to also capture TPH enable and steering-tag mode.
module pcie_msix_shdw_tracker
    import pcie_msix_shdw_pkg::*;
#(
    parameter int NUM_PFS      = 1,
    parameter int NUM_VFS      = 4,
    parameter int SCAN_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    pcie_msix_shdw_tracker_if.slave  bus
);

    t_shdw_cfg          cfg;
    logic               vf_hit, pf_hit, upd_acc;
    logic [NUM_VFS-1:0] vf_en_q, vf_en_d, vf_mask_q, vf_mask_d;
    logic [NUM_PFS-1:0] pf_en_q, pf_en_d, pf_mask_q, pf_mask_d, pf_bme_q, pf_bme_d;
    logic               range_err_q, range_err_d;
    logic               lk_vld_q, lk_en_q, lk_en_d, lk_mask_q, lk_mask_d;
`ifdef MSIX_SHDW_TPH_EN
    logic [NUM_VFS-1:0]   vf_tph_en_q, vf_tph_en_d;
    logic [2*NUM_VFS-1:0] vf_tph_st_q, vf_tph_st_d;
    logic [NUM_PFS-1:0]   pf_tph_en_q, pf_tph_en_d;
    logic [2*NUM_PFS-1:0] pf_tph_st_q, pf_tph_st_d;
`else
    logic                 unused_tph_cfg;
    assign unused_tph_cfg = ^{cfg.tph_req_en, cfg.tph_st_mode};
`endif
    logic                 unused_ats_cfg;

    assign cfg            = t_shdw_cfg'(bus.ctl_shdw_cfg);
    assign unused_ats_cfg = cfg.ats_en;

    // Decode by comparing against every table index so that out-of-range
    // numbers simply hit nothing, which doubles as the range check.
    always_comb begin
        vf_en_d   = vf_en_q;
        vf_mask_d = vf_mask_q;
        pf_en_d   = pf_en_q;
        pf_mask_d = pf_mask_q;
        pf_bme_d  = pf_bme_q;
`ifdef MSIX_SHDW_TPH_EN
        vf_tph_en_d = vf_tph_en_q;
        vf_tph_st_d = vf_tph_st_q;
        pf_tph_en_d = pf_tph_en_q;
        pf_tph_st_d = pf_tph_st_q;
`endif
        vf_hit = 1'b0;
        pf_hit = 1'b0;
        for (int i = 0; i < NUM_VFS; i++) begin
            if (SHDW_VF_NUM_W'(i) == bus.ctl_shdw_vf_num) begin
                vf_hit = 1'b1;
                if (bus.ctl_shdw_update && bus.ctl_shdw_vf_active) begin
                    vf_en_d[i]   = cfg.msix_en;
                    vf_mask_d[i] = cfg.fn_mask;
`ifdef MSIX_SHDW_TPH_EN
                    vf_tph_en_d[i]       = cfg.tph_req_en;
                    vf_tph_st_d[2*i +: 2] = cfg.tph_st_mode;
`endif
                end
            end
        end
        for (int i = 0; i < NUM_PFS; i++) begin
            if (SHDW_PF_NUM_W'(i) == bus.ctl_shdw_pf_num) begin
                pf_hit = 1'b1;
                if (bus.ctl_shdw_update && !bus.ctl_shdw_vf_active) begin
                    pf_en_d[i]   = cfg.msix_en;
                    pf_mask_d[i] = cfg.fn_mask;
                    pf_bme_d[i]  = cfg.bme;
`ifdef MSIX_SHDW_TPH_EN
                    pf_tph_en_d[i]       = cfg.tph_req_en;
                    pf_tph_st_d[2*i +: 2] = cfg.tph_st_mode;
`endif
                end
            end
        end
        upd_acc     = bus.ctl_shdw_update && (bus.ctl_shdw_vf_active ? vf_hit : pf_hit);
        range_err_d = range_err_q | (bus.ctl_shdw_update & ~upd_acc);
    end

    // Lookup reads the registered table, so a same-cycle update is not visible.
    always_comb begin
        lk_en_d   = 1'b0;
        lk_mask_d = 1'b1;
        if (bus.lkup_vf_active) begin
            for (int i = 0; i < NUM_VFS; i++) begin
                if (SHDW_VF_NUM_W'(i) == bus.lkup_num) begin
                    lk_en_d   = vf_en_q[i];
                    lk_mask_d = vf_mask_q[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_PFS; i++) begin
                if (SHDW_VF_NUM_W'(i) == bus.lkup_num) begin
                    lk_en_d   = pf_en_q[i];
                    lk_mask_d = pf_mask_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vf_en_q     <= '0;
            vf_mask_q   <= '0;
            pf_en_q     <= '0;
            pf_mask_q   <= '0;
            pf_bme_q    <= '0;
            range_err_q <= 1'b0;
            lk_vld_q    <= 1'b0;
            lk_en_q     <= 1'b0;
            lk_mask_q   <= 1'b0;
`ifdef MSIX_SHDW_TPH_EN
            vf_tph_en_q <= '0;
            vf_tph_st_q <= '0;
            pf_tph_en_q <= '0;
            pf_tph_st_q <= '0;
`endif
        end else begin
            vf_en_q     <= vf_en_d;
            vf_mask_q   <= vf_mask_d;
            pf_en_q     <= pf_en_d;
            pf_mask_q   <= pf_mask_d;
            pf_bme_q    <= pf_bme_d;
            range_err_q <= range_err_d;
            lk_vld_q    <= bus.lkup_valid;
            lk_en_q     <= lk_en_d;
            lk_mask_q   <= lk_mask_d;
`ifdef MSIX_SHDW_TPH_EN
            vf_tph_en_q <= vf_tph_en_d;
            vf_tph_st_q <= vf_tph_st_d;
            pf_tph_en_q <= pf_tph_en_d;
            pf_tph_st_q <= pf_tph_st_d;
`endif
        end
    end

    pcie_msix_shdw_seq #(
        .NUM_FUNCS    (NUM_PFS + NUM_VFS),
        .SCAN_TIMEOUT (SCAN_TIMEOUT)
    ) u_seq (
        .clk          (clk),
        .reset        (reset),
        .resync_req_i (bus.resync_req),
        .upd_acc_i    (upd_acc),
        .req_all_o    (bus.ctl_shdw_req_all),
        .synced_o     (bus.shdw_synced)
    );

    assign bus.pf_msix_en     = pf_en_q;
    assign bus.pf_msix_mask   = pf_mask_q;
    assign bus.pf_bme         = pf_bme_q;
    assign bus.vf_msix_en     = vf_en_q;
    assign bus.vf_msix_mask   = vf_mask_q;
    assign bus.shdw_range_err = range_err_q;
    assign bus.lkup_rsp_valid = lk_vld_q;
    assign bus.lkup_rsp_en    = lk_en_q;
    assign bus.lkup_rsp_mask  = lk_mask_q;
`ifdef MSIX_SHDW_TPH_EN
    assign bus.vf_tph_en      = vf_tph_en_q;
    assign bus.vf_tph_st_mode = vf_tph_st_q;
    assign bus.pf_tph_en      = pf_tph_en_q;
    assign bus.pf_tph_st_mode = pf_tph_st_q;
`endif

endmodule

// File: tb/tb_pcie_msix_shdw_tracker.sv
// Scoreboard bench for pcie_msix_shdw_tracker (NUM_PFS=1, NUM_VFS=4, SCAN_TIMEOUT=16).
module tb_pcie_msix_shdw_tracker;

    localparam int NP  = 1;
    localparam int NV  = 4;
    localparam int TMO = 16;

    logic clk;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] lk_q[$];
    int         req_q[$];

    pcie_msix_shdw_tracker_if #(.NUM_PFS(NP), .NUM_VFS(NV)) bus ();

    pcie_msix_shdw_tracker #(
        .NUM_PFS(NP), .NUM_VFS(NV), .SCAN_TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected lookup responses and expected req_all cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.lkup_rsp_valid) begin
                if (lk_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lkup_rsp: unexpected response en=%0b mask=%0b", bus.lkup_rsp_en, bus.lkup_rsp_mask);
                end else begin
                    chk("lkup_rsp", 32'({bus.lkup_rsp_en, bus.lkup_rsp_mask}), 32'(lk_q.pop_front()));
                end
            end
            if (bus.ctl_shdw_req_all) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_all: unexpected pulse at cycle %0d, none expected", cyc);
                end else begin
                    chk("req_all_cycle", 32'(cyc), 32'(req_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic vfa, input logic [1:0] pf, input logic [10:0] vf, input logic [6:0] cfg);
        bus.ctl_shdw_update    = 1'b1;
        bus.ctl_shdw_vf_active = vfa;
        bus.ctl_shdw_pf_num    = pf;
        bus.ctl_shdw_vf_num    = vf;
        bus.ctl_shdw_cfg       = cfg;
        tick();
        bus.ctl_shdw_update    = 1'b0;
    endtask

    task automatic lkup(input logic vfa, input logic [10:0] num, input logic [1:0] exp);
        lk_q.push_back(exp);
        bus.lkup_valid     = 1'b1;
        bus.lkup_vf_active = vfa;
        bus.lkup_num       = num;
        tick();
        bus.lkup_valid     = 1'b0;
    endtask

    task automatic resync();
        req_q.push_back(cyc + 1);
        bus.resync_req = 1'b1;
        tick();
        bus.resync_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b1;
        bus.resync_req         = 1'b0;
        bus.ctl_shdw_update    = 1'b0;
        bus.ctl_shdw_pf_num    = '0;
        bus.ctl_shdw_vf_num    = '0;
        bus.ctl_shdw_vf_active = 1'b0;
        bus.ctl_shdw_cfg       = '0;
        bus.lkup_valid         = 1'b0;
        bus.lkup_vf_active     = 1'b0;
        bus.lkup_num           = '0;
        repeat (3) tick();

        chk("rst_req_all", 32'(bus.ctl_shdw_req_all), 32'd0);
        chk("rst_synced", 32'(bus.shdw_synced), 32'd0);
        chk("rst_range_err", 32'(bus.shdw_range_err), 32'd0);
        chk("rst_vf_en", 32'(bus.vf_msix_en), 32'd0);
        chk("rst_pf_en", 32'(bus.pf_msix_en), 32'd0);
        chk("rst_lkup_vld", 32'(bus.lkup_rsp_valid), 32'd0);

        // Reset release: req_all on the 2nd cycle, then SCAN.
        reset = 1'b0;
        req_q.push_back(cyc + 1);
        tick();
        chk("req_all_hi", 32'(bus.ctl_shdw_req_all), 32'd1);
        tick();
        chk("req_all_lo", 32'(bus.ctl_shdw_req_all), 32'd0);

        upd(1'b0, 2'd0, 11'd0, 7'b0000000);
        upd(1'b1, 2'd0, 11'd0, 7'b0000000);
        upd(1'b1, 2'd0, 11'd1, 7'b0000000);
        upd(1'b1, 2'd0, 11'd2, 7'b0000110);
        chk("vf2_en", 32'(bus.vf_msix_en), 32'b0100);
        chk("vf2_mask", 32'(bus.vf_msix_mask), 32'b0100);
        chk("synced_4of5", 32'(bus.shdw_synced), 32'd0);
        upd(1'b1, 2'd0, 11'd3, 7'b0000000);
        chk("synced_5of5", 32'(bus.shdw_synced), 32'd1);
        chk("range_err_clean", 32'(bus.shdw_range_err), 32'd0);

        lkup(1'b1, 11'd2, 2'b11);
        lkup(1'b0, 11'd0, 2'b00);
        lkup(1'b1, 11'd1, 2'b00);

        // Out-of-range updates and lookups.
        upd(1'b1, 2'd0, 11'd4, 7'b0000110);
        chk("oor_vf_en", 32'(bus.vf_msix_en), 32'b0100);
        chk("oor_vf_mask", 32'(bus.vf_msix_mask), 32'b0100);
        chk("oor_range_err", 32'(bus.shdw_range_err), 32'd1);
        upd(1'b0, 2'd1, 11'd0, 7'b0000111);
        chk("oor_pf_en", 32'(bus.pf_msix_en), 32'd0);
        chk("oor_pf_bme", 32'(bus.pf_bme), 32'd0);
        lkup(1'b1, 11'd9, 2'b01);
        lkup(1'b0, 11'd3, 2'b01);

        // Lookup sees the table before a same-cycle update.
        lk_q.push_back(2'b11);
        bus.lkup_valid         = 1'b1;
        bus.lkup_vf_active     = 1'b1;
        bus.lkup_num           = 11'd2;
        bus.ctl_shdw_update    = 1'b1;
        bus.ctl_shdw_vf_active = 1'b1;
        bus.ctl_shdw_vf_num    = 11'd2;
        bus.ctl_shdw_cfg       = 7'b0000000;
        tick();
        bus.lkup_valid      = 1'b0;
        bus.ctl_shdw_update = 1'b0;
        chk("samecyc_vf_en", 32'(bus.vf_msix_en), 32'd0);
        chk("range_err_sticky", 32'(bus.shdw_range_err), 32'd1);

        // resync in TRACK together with a PF0 update, then timeout path.
        req_q.push_back(cyc + 1);
        bus.resync_req         = 1'b1;
        bus.ctl_shdw_update    = 1'b1;
        bus.ctl_shdw_vf_active = 1'b0;
        bus.ctl_shdw_pf_num    = 2'd0;
        bus.ctl_shdw_cfg       = 7'b0000101;
        tick();
        bus.resync_req      = 1'b0;
        bus.ctl_shdw_update = 1'b0;
        chk("resync_synced", 32'(bus.shdw_synced), 32'd0);
        chk("resync_req_all", 32'(bus.ctl_shdw_req_all), 32'd1);
        chk("resync_pf_en", 32'(bus.pf_msix_en), 32'd1);
        chk("resync_pf_bme", 32'(bus.pf_bme), 32'd1);
        chk("resync_pf_mask", 32'(bus.pf_msix_mask), 32'd0);
        tick();
        chk("scan_req_all_lo", 32'(bus.ctl_shdw_req_all), 32'd0);
        upd(1'b1, 2'd0, 11'd0, 7'b0000000);
        upd(1'b1, 2'd0, 11'd1, 7'b0000000);
        upd(1'b1, 2'd0, 11'd3, 7'b0000000);
        repeat (11) tick();
        chk("tmo_synced_15", 32'(bus.shdw_synced), 32'd0);
        tick();
        chk("tmo_synced_16", 32'(bus.shdw_synced), 32'd1);

        // resync during SCAN restarts; repeated PF0 updates each count.
        resync();
        tick();
        resync();
        chk("restart_synced", 32'(bus.shdw_synced), 32'd0);
        tick();
        repeat (4) upd(1'b0, 2'd0, 11'd0, 7'b0000101);
        chk("rep_synced_4", 32'(bus.shdw_synced), 32'd0);
        upd(1'b0, 2'd0, 11'd0, 7'b0000101);
        chk("rep_synced_5", 32'(bus.shdw_synced), 32'd1);
        lkup(1'b0, 11'd0, 2'b10);

`ifdef MSIX_SHDW_TPH_EN
        upd(1'b1, 2'd0, 11'd1, 7'b0110000);
        chk("tph_vf1_en", 32'(bus.vf_tph_en), 32'b0010);
        chk("tph_vf1_st", 32'(bus.vf_tph_st_mode[3:2]), 32'b10);
`endif

        repeat (3) tick();
        chk("lkup_q_drained", 32'(lk_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_msix_shdw_tracker.md
Name: pcie_msix_shdw_tracker

Overview:
- Parametrised successor to the single-VF MSI-X shadow capture logic.
- Tracks MSI-X enable, function mask and bus-master enable for every PF and VF from the PCIe EP control-shadow interface, in the avl clock domain.
- Sequences the startup req_all/update handshake and provides flat status vectors plus a registered per-function lookup port for the FIM MSI-X table logic.
- Output is resynchronised downstream; resync is not part of this block.

Parameters:
- NUM_PFS, 1, physical functions tracked (1..4).
- NUM_VFS, 4, VFs tracked, numbered 0..NUM_VFS-1 (1..2048).
- SCAN_TIMEOUT, 4096, cycles allowed in SCAN before giving up.

Ports:
- clk  in  1  avl clock.
- reset  in  1  synchronous, active-high reset.
- resync_req  in  1  one-cycle pulse; re-runs the full-shadow request.
- ctl_shdw_update  in  1  shadow update strobe, valid for one cycle.
- ctl_shdw_pf_num  in  2  PF of the update.
- ctl_shdw_vf_num  in  11  VF of the update.
- ctl_shdw_vf_active  in  1  1 = VF update, 0 = PF update.
- ctl_shdw_cfg  in  7  [6] ATS en, [5] TPH req en, [4:3] TPH ST mode, [2] MSI-X en, [1] function mask, [0] bus master en.
- ctl_shdw_req_all  out  1  request that the EP replay all shadow registers.
- pf_msix_en  out  NUM_PFS  per-PF MSI-X enable.
- pf_msix_mask  out  NUM_PFS  per-PF function mask.
- pf_bme  out  NUM_PFS  per-PF bus master enable.
- vf_msix_en  out  NUM_VFS  per-VF MSI-X enable.
- vf_msix_mask  out  NUM_VFS  per-VF function mask.
- lkup_valid  in  1  lookup request.
- lkup_vf_active  in  1  lookup target is a VF.
- lkup_num  in  11  PF or VF number to look up.
- lkup_rsp_valid  out  1  lookup response valid.
- lkup_rsp_en  out  1  looked-up MSI-X enable.
- lkup_rsp_mask  out  1  looked-up function mask.
- shdw_synced  out  1  a full scan has completed since the last request.
- shdw_range_err  out  1  sticky: an update arrived with an out-of-range PF or VF number.

Behaviour:
- Reset: all outputs and table bits clear to 0; FSM enters IDLE.
- FSM, IDLE: go to REQ on the first cycle after reset deasserts, or on resync_req.
- FSM, REQ: ctl_shdw_req_all=1 for exactly one cycle; clear the scan counter and the timeout counter; go to SCAN.
- FSM, SCAN: count accepted updates. Go to TRACK when count == NUM_PFS+NUM_VFS, or when timeout reaches SCAN_TIMEOUT-1.
- FSM, TRACK: entering TRACK sets shdw_synced=1 on either exit path, including timeout. resync_req returns to REQ and clears shdw_synced in the same cycle.
- Updates are applied in every state, SCAN and TRACK included. An update on the same cycle as resync_req is applied.
- Update latency: the table bit changes on the cycle after ctl_shdw_update.
- VF update: ctl_shdw_vf_active=1 and vf_num < NUM_VFS writes vf_msix_en[vf_num]=cfg[2] and vf_msix_mask[vf_num]=cfg[1].
- PF update: ctl_shdw_vf_active=0 and pf_num < NUM_PFS writes cfg[2], cfg[1] and cfg[0] into the PF vectors.
- Out-of-range update: table is unchanged, shdw_range_err is set (cleared only by reset), and it is not counted in SCAN.
- Repeated updates to the same function count each time; the counter saturates at its target.
- Scan counter width is $clog2(NUM_PFS+NUM_VFS+1); no wrap.
- Lookup: fixed 1-cycle latency. lkup_rsp_valid follows lkup_valid by one cycle. Response reflects table contents before any same-cycle update.
- Lookup out of range: response is en=0, mask=1 (safe default).
- resync_req while already in REQ or SCAN restarts the scan: back to REQ, req_all pulses again.

Optional Feature:
- Macro: MSIX_SHDW_TPH_EN.
- Defined: adds outputs vf_tph_en[NUM_VFS], vf_tph_st_mode[2*NUM_VFS], pf_tph_en[NUM_PFS] and pf_tph_st_mode[2*NUM_PFS], captured from cfg[5] and cfg[4:3] under the same write and range rules. All reset to 0.
- Undefined: these ports do not exist and cfg[6:3] is ignored.

Decomposition:
- Package pcie_msix_shdw_pkg holds:
  - typedef t_shdw_state (IDLE, REQ, SCAN, TRACK);
  - typedef t_shdw_cfg, a packed struct of the 7 cfg bits;
  - constants SHDW_VF_NUM_W=11 and SHDW_PF_NUM_W=2.
- One sub-module, pcie_msix_shdw_seq: the FSM, scan counter and timeout counter. The table and lookup stay in the top.

Test Plan:
- Reset release, NUM_PFS=1, NUM_VFS=4 -> req_all high for one cycle on the 2nd cycle after reset; 5 updates -> shdw_synced=1 on the cycle after the 5th.
- VF update vf_num=2, cfg=7'b0000110 -> next cycle vf_msix_en=4'b0100, vf_msix_mask=4'b0100; lookup VF2 -> en=1, mask=1 after one cycle.
- VF update vf_num=4 with NUM_VFS=4 -> tables unchanged, shdw_range_err=1; lookup VF9 -> en=0, mask=1.
- Only 3 updates during SCAN, SCAN_TIMEOUT=16 -> TRACK and shdw_synced=1 exactly 16 cycles after the REQ cycle.
- resync_req in TRACK together with PF0 update cfg=7'b0000101 -> shdw_synced=0, req_all pulses next cycle, pf_msix_en[0]=1 and pf_bme[0]=1.
- With MSIX_SHDW_TPH_EN, VF1 update cfg=7'b0110000 -> vf_tph_en[1]=1, vf_tph_st_mode[3:2]=2'b10.
